// File: rtl/rf_sched_pkg.sv
// Shared types and default sizing for the register-file write scheduler.
// The FSM has only two states: the init sweep, then normal arbitration.
package rf_sched_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_NREG = 16;
  localparam int DEF_AW   = 4;
  localparam int DEF_DW   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0. Pure combinational.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand_s;

  // Scan candidates in priority order starting at ptr; the first hit wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!any && (cand_s == i) && req[i]) begin
          gnt[i] = 1'b1;
          idx    = IW'(i);
          any    = 1'b1;
        end else begin
          any    = any;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the single register-file write port: init sweep after reset, then
// round-robin sharing among requesters plus a per-register busy scoreboard.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int             NREQ     = 2,
  parameter int             NREG     = DEF_NREG,
  parameter int             AW       = DEF_AW,
  parameter int             DW       = DEF_DW,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  output logic                 claim_ready,
  output logic [NREG-1:0]      busy,
  output logic                 we_RF,
  output logic [AW-1:0]        rd,
  output logic [DW-1:0]        WD3,
  output logic                 init_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_r;
  state_t            nstate_s;
  logic [AW-1:0]     ptr_r;
  logic [IW-1:0]     rr_r;
  logic [IW-1:0]     rr_nxt_s;
  logic [NREQ-1:0]   gnt_s;
  logic [IW-1:0]     idx_s;
  logic              any_s;
  logic              grant_s;
  logic [AW-1:0]     gnt_addr_s;
  logic [DW-1:0]     gnt_data_s;
  logic [NREG-1:0]   busy_nxt_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_r),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );

  // Next state and the combinational handshake outputs.
  always_comb begin
    nstate_s    = state_r;
    req_ready   = '0;
    claim_ready = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (ptr_r == AW'(NREG - 1)) begin
          nstate_s = ST_RUN;
        end else begin
          nstate_s = ST_INIT;
        end
      end
      ST_RUN: begin
        req_ready   = gnt_s;
        claim_ready = 1'b1;
      end
      default: begin
        nstate_s = ST_INIT;
      end
    endcase
  end

  assign grant_s = (state_r == ST_RUN) && any_s;

  // Mux the granted requester's address/data and work out the next rr pointer.
  always_comb begin
    gnt_addr_s = '0;
    gnt_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        gnt_addr_s = req_addr[i*AW +: AW];
        gnt_data_s = req_data[i*DW +: DW];
      end else begin
        gnt_addr_s = gnt_addr_s;
      end
    end
    if (idx_s == IW'(NREQ - 1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = idx_s + IW'(1);
    end
  end

  // Scoreboard update: retire first, then claim, so a same-edge claim wins.
  always_comb begin
    busy_nxt_s = busy;
    if (grant_s) begin
      busy_nxt_s[gnt_addr_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (claim_valid && claim_ready) begin
      busy_nxt_s[claim_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // State, sweep counter, rr pointer, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_INIT;
      ptr_r     <= '0;
      rr_r      <= '0;
      busy      <= '0;
      we_RF     <= 1'b0;
      rd        <= '0;
      WD3       <= '0;
      init_done <= 1'b0;
    end else begin
      state_r <= nstate_s;
      busy    <= busy_nxt_s;
      case (state_r)
        ST_INIT: begin
          we_RF <= 1'b1;
          rd    <= ptr_r;
          WD3   <= INIT_VAL;
          ptr_r <= ptr_r + AW'(1);
        end
        ST_RUN: begin
          init_done <= 1'b1;
          if (grant_s) begin
            we_RF <= 1'b1;
            rd    <= gnt_addr_s;
            WD3   <= gnt_data_s;
            rr_r  <= rr_nxt_s;
          end else begin
            we_RF <= 1'b0;
          end
        end
        default: begin
          we_RF <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomized scoreboard bench for rf_write_scheduler: a reference model predicts
// grants, busy bits and the write stream; a negedge monitor checks RF writes.
module tb_rf_write_scheduler;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        claim_valid = 1'b0;
  logic [3:0]  claim_addr = '0;
  logic        claim_ready;
  logic [15:0] busy;
  logic        we_RF;
  logic [3:0]  rd;
  logic [31:0] WD3;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         exp_q[$];
  int          m_edges;
  int          m_rr;
  logic [15:0] m_busy;
  logic [3:0]  last_rd;
  logic [31:0] last_wd;

  rf_write_scheduler #(.NREQ(2), .NREG(16), .AW(4), .DW(32), .INIT_VAL(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .busy        (busy),
    .we_RF       (we_RF),
    .rd          (rd),
    .WD3         (WD3),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write; idle cycles hold rd/WD3.
  always @(negedge clk) begin
    if (!rst) begin
      last_rd = 4'h0;
      last_wd = 32'h0;
    end else if (we_RF === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {28'h0, rd}, 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_rd", {60'h0, rd}, {60'h0, e.a});
        chk("write_wd3", {32'h0, WD3}, {32'h0, e.d});
      end
      last_rd = rd;
      last_wd = WD3;
    end else begin
      chk("hold_rd", {60'h0, rd}, {60'h0, last_rd});
      chk("hold_wd3", {32'h0, WD3}, {32'h0, last_wd});
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b0;
    req_valid = '0;
    claim_valid = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_we", {63'h0, we_RF}, 64'h0);
    chk("rst_init_done", {63'h0, init_done}, 64'h0);
    chk("rst_busy", {48'h0, busy}, 64'h0);
    chk("rst_rd_wd3", {28'h0, rd, WD3}, 64'h0);
    chk("rst_ready", {61'h0, req_ready, claim_ready}, 64'h0);
    m_edges = 0;
    m_rr    = 0;
    m_busy  = 16'h0;
    for (int r = 0; r < 16; r++) begin
      wr_t e;
      e.a = 4'(r);
      e.d = 32'h0;
      exp_q.push_back(e);
    end
    rst = 1'b1;
  endtask

  // One clock cycle of stimulus; called just after a posedge, returns just after the next.
  task automatic step(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic cv, input logic [3:0] ca);
    int   g;
    int   j;
    bit   run;
    logic [3:0]  addr [2];
    logic [31:0] data [2];
    logic [1:0]  exp_rdy;
    addr[0] = a0; addr[1] = a1;
    data[0] = d0; data[1] = d1;
    req_valid   = v;
    req_addr    = {a1, a0};
    req_data    = {d1, d0};
    claim_valid = cv;
    claim_addr  = ca;
    #1;
    run = (m_edges >= 16);
    g = -1;
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        j = (m_rr + k) % 2;
        if (g < 0 && v[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    chk("req_ready", {62'h0, req_ready}, {62'h0, exp_rdy});
    chk("claim_ready", {63'h0, claim_ready}, {63'h0, run});
    if (g >= 0) begin
      wr_t e;
      e.a = addr[g];
      e.d = data[g];
      exp_q.push_back(e);
      m_busy[addr[g]] = 1'b0;
      m_rr = (g + 1) % 2;
    end
    if (run && cv) m_busy[ca] = 1'b1;
    @(posedge clk);
    m_edges++;
    #1;
    chk("busy", {48'h0, busy}, {48'h0, m_busy});
    chk("init_done", {63'h0, init_done}, {63'h0, (m_edges >= 17)});
  endtask

  task automatic rand_step();
    step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic idle();
    step(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    m_edges = 0;
    m_rr = 0;
    m_busy = 16'h0;
    do_reset(2);
    // Reset at sweep cycle 8, with requests and claims that must be refused.
    repeat (8) rand_step();
    do_reset(2);
    repeat (17) rand_step();
    repeat (4) idle();
    // Single write of 0xDEADBEEF to r5.
    step(2'b01, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 1'b0, 4'h0);
    idle();
    // Both requesters held valid: strict alternation.
    repeat (4) step(2'b11, 4'd1, 4'd2, 32'h1111_0001, 32'h2222_0002, 1'b0, 4'h0);
    // Claim r7, then requester 1 retires it.
    step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd7);
    idle();
    step(2'b10, 4'd0, 4'd7, 32'h0, 32'h7777_7777, 1'b0, 4'h0);
    // Claim and retire r3 on the same edge: claim wins.
    step(2'b01, 4'd3, 4'd0, 32'h3333_3333, 32'h0, 1'b1, 4'd3);
    idle();
    repeat (300) rand_step();
    // Reset in the middle of RUN.
    do_reset(3);
    repeat (120) rand_step();
    repeat (3) idle();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
